// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART receiver types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 868;
    localparam int TIMER_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_bit_timer
// Description : Loadable down-counter; expire pulses in the cycle the count is 1.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] r_count;

    // A load of N produces expire exactly N cycles after the loading cycle.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expire = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_controller
// Description : UART receiver with parity/frame checks and a one-deep output slot.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 rx_valid_out,
    input  logic                 rx_ready_in,
    output logic                 parity_err_out,
    output logic                 frame_err_out,
    output logic                 overrun_err_out,
    output logic                 busy_out
);

    localparam logic [TIMER_W-1:0] c_half_bit = TIMER_W'(BAUD_DIV / 2);
    localparam logic [TIMER_W-1:0] c_full_bit = TIMER_W'(BAUD_DIV);
    localparam logic               c_odd      = 1'(PARITY_ODD);
    localparam logic [2:0]         c_last_idx = 3'(DATA_BITS - 1);

    rx_state_t              r_state;
    rx_state_t              w_next_state;
    logic [1:0]             r_sync;
    logic                   w_rxs;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   w_timer_load;
    logic [TIMER_W-1:0]     w_timer_value;
    logic                   w_expire;
    logic                   w_sample_data;
    logic                   w_sample_par;
    logic                   w_complete;
    logic                   w_slot_free;

    assign w_rxs    = r_sync[1];
    assign busy_out = (r_state != ST_IDLE);

    uart_rx_bit_timer #(
        .WIDTH      (TIMER_W)
    ) u_bit_timer (
        .Clk        (Clk),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (w_timer_value),
        .expire     (w_expire)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = c_full_bit;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_complete    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_rxs) begin
                    w_next_state  = ST_START;
                    w_timer_load  = 1'b1;
                    w_timer_value = c_half_bit;
                end
            end
            ST_START: begin
                if (w_expire) begin
                    if (!w_rxs) begin
                        w_next_state = ST_DATA;
                        w_timer_load = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    w_sample_data = 1'b1;
                    w_timer_load  = 1'b1;
                    if (r_bit_idx == c_last_idx) begin
                        w_next_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_expire) begin
                    w_sample_par = 1'b1;
                    w_timer_load = 1'b1;
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_expire) begin
                    w_complete   = 1'b1;
                    w_next_state = w_rxs ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rxs) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // A byte being consumed in the completion cycle frees the slot for the new one.
    assign w_slot_free = !rx_valid_out || rx_ready_in;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_sync          <= 2'b11;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_par_err       <= 1'b0;
            rx_data_out     <= '0;
            rx_valid_out    <= 1'b0;
            parity_err_out  <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx_in};

            if (w_sample_data) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {w_rxs, r_shift[DATA_BITS-1:1]};
            end else if (r_state == ST_START) begin
                r_bit_idx <= '0;
            end

            if (w_sample_par) begin
                r_par_err <= ((^r_shift) ^ w_rxs) != c_odd;
            end

            overrun_err_out <= w_complete && !w_slot_free;

            if (w_complete && w_slot_free) begin
                rx_data_out    <= r_shift;
                rx_valid_out   <= 1'b1;
                parity_err_out <= (PARITY_EN != 0) && r_par_err;
                frame_err_out  <= !w_rxs;
            end else if (rx_valid_out && rx_ready_in) begin
                rx_valid_out   <= 1'b0;
                parity_err_out <= 1'b0;
                frame_err_out  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_controller
// Description : Scoreboard bench for uart_rx_controller (16 clk/bit, even parity).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_controller;

    localparam int BD = 16;

    logic       Clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       rx_ready_in;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       parity_err_out;
    logic       frame_err_out;
    logic       overrun_err_out;
    logic       busy_out;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       sb_q[$];
    int         n_total  = 0;
    int         n_bad    = 0;
    int         ov_seen  = 0;
    logic       ov_prev  = 1'b0;
    logic       hold_prev = 1'b0;
    logic [9:0] hold_bits = '0;

    always #5 Clk = ~Clk;

    uart_rx_controller #(
        .BAUD_DIV        (BD),
        .PARITY_EN       (1),
        .PARITY_ODD      (0)
    ) u_dut (
        .Clk             (Clk),
        .reset           (reset),
        .rx_in           (rx_in),
        .rx_data_out     (rx_data_out),
        .rx_valid_out    (rx_valid_out),
        .rx_ready_in     (rx_ready_in),
        .parity_err_out  (parity_err_out),
        .frame_err_out   (frame_err_out),
        .overrun_err_out (overrun_err_out),
        .busy_out        (busy_out)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Start bit goes low just after a rising edge; each bit lasts BD cycles.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit keep_low);
        @(posedge Clk);
        #1 rx_in = 1'b0;
        repeat (BD) @(posedge Clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_in = d[i];
            repeat (BD) @(posedge Clk);
        end
        #1 rx_in = par;
        repeat (BD) @(posedge Clk);
        #1 rx_in = stop;
        repeat (BD) @(posedge Clk);
        if (!keep_low) begin
            #1 rx_in = 1'b1;
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        sb_q.push_back(e);
    endtask

    // Output monitor: pops on every accepted byte, watches overrun and hold stability.
    always @(negedge Clk) begin
        if (reset) begin
            ov_prev   = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check_val("hold_stable", 32'(hold_bits),
                          32'({rx_data_out, parity_err_out, frame_err_out}));
            end
            if (rx_valid_out && rx_ready_in) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_byte", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_val("rx_data", 32'(rx_data_out), 32'(e.data));
                    check_val("parity_err", 32'(parity_err_out), 32'(e.perr));
                    check_val("frame_err", 32'(frame_err_out), 32'(e.ferr));
                end
            end
            if (overrun_err_out) begin
                ov_seen++;
                check_val("overrun_single", 32'(ov_prev), 32'd0);
            end
            ov_prev   = overrun_err_out;
            hold_prev = rx_valid_out && !rx_ready_in;
            hold_bits = {rx_data_out, parity_err_out, frame_err_out};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        rx_in       = 1'b1;
        rx_ready_in = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_data", 32'(rx_data_out), 32'd0);
        check_val("rst_valid", 32'(rx_valid_out), 32'd0);
        check_val("rst_busy", 32'(busy_out), 32'd0);
        check_val("rst_perr", 32'(parity_err_out), 32'd0);
        check_val("rst_ferr", 32'(frame_err_out), 32'd0);
        check_val("rst_ovr", 32'(overrun_err_out), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge Clk);

        // Clean byte: latency from line fall to valid, and a single-cycle valid.
        push_exp(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, even_par(8'hA5), 1'b1, 1'b0);
            begin
                int n;
                bit seen;
                @(posedge Clk);
                #1;
                n    = 0;
                seen = 1'b0;
                while (!seen && n < 400) begin
                    @(posedge Clk);
                    n++;
                    @(negedge Clk);
                    if (rx_valid_out) seen = 1'b1;
                end
                check_val("valid_latency", 32'(n), 32'd171);
                @(negedge Clk);
                check_val("valid_one_cycle", 32'(rx_valid_out), 32'd0);
            end
        join
        repeat (20) @(posedge Clk);

        // Wrong parity bit.
        push_exp(8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        repeat (20) @(posedge Clk);

        // Stop bit low, line held low: frame error and break handling.
        push_exp(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, even_par(8'h3C), 1'b0, 1'b1);
        repeat (40) @(posedge Clk);
        #1 check_val("break_busy", 32'(busy_out), 32'd1);
        rx_in = 1'b1;
        repeat (5) @(posedge Clk);
        #1 check_val("break_exit_busy", 32'(busy_out), 32'd0);
        push_exp(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, even_par(8'h55), 1'b1, 1'b0);
        repeat (20) @(posedge Clk);

        // Overrun: consumer stalled, second byte dropped.
        #1 rx_ready_in = 1'b0;
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, even_par(8'h11), 1'b1, 1'b0);
        repeat (20) @(posedge Clk);
        send_frame(8'h22, even_par(8'h22), 1'b1, 1'b0);
        repeat (20) @(posedge Clk);
        #1;
        check_val("ovr_count", 32'(ov_seen), 32'd1);
        check_val("ovr_keep_data", 32'(rx_data_out), 32'h11);
        check_val("ovr_keep_valid", 32'(rx_valid_out), 32'd1);

        // Ready rises in the completion cycle: new byte loads, no overrun.
        push_exp(8'h22, 1'b0, 1'b0);
        fork
            send_frame(8'h22, even_par(8'h22), 1'b1, 1'b0);
            begin
                @(posedge Clk);
                #1;
                repeat (170) @(posedge Clk);
                #1 rx_ready_in = 1'b1;
            end
        join
        repeat (20) @(posedge Clk);
        #1;
        check_val("simul_no_ovr", 32'(ov_seen), 32'd1);
        check_val("simul_sb_empty", 32'(sb_q.size()), 32'd0);

        // Short glitch in idle is rejected as a false start.
        @(posedge Clk);
        #1 rx_in = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check_val("glitch_busy", 32'(busy_out), 32'd1);
        rx_in = 1'b1;
        repeat (30) @(posedge Clk);
        #1;
        check_val("glitch_no_valid", 32'(rx_valid_out), 32'd0);
        check_val("glitch_idle", 32'(busy_out), 32'd0);

        // Reset during data bit 4 abandons the frame.
        fork
            send_frame(8'hE0, even_par(8'hE0), 1'b1, 1'b0);
            begin
                @(posedge Clk);
                #1;
                repeat (88) @(posedge Clk);
                #1 reset = 1'b1;
                #1;
                check_val("async_rst_busy", 32'(busy_out), 32'd0);
                repeat (12) @(posedge Clk);
                #1 reset = 1'b0;
            end
        join
        repeat (30) @(posedge Clk);
        #1;
        check_val("abandon_no_valid", 32'(rx_valid_out), 32'd0);
        check_val("abandon_idle", 32'(busy_out), 32'd0);
        check_val("abandon_no_ovr", 32'(ov_seen), 32'd1);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, even_par(8'h5A), 1'b1, 1'b0);
        repeat (20) @(posedge Clk);
        #1;
        check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
